// File: rtl/shift_ex_stage_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// shift_ex_stage_if : ID/EX, forwarding, hazard and EX/MEM signals of the shift stage
// Revision 1.0
// ----------------------------------------------------------------------------
interface shift_ex_stage_if #(
    parameter int DATA_W = 16,
    parameter int REG_W  = 4
);
    logic              id_valid;
    logic [1:0]        id_op;
    logic [REG_W-1:0]  id_rs_addr;
    logic [DATA_W-1:0] id_rs_data;
    logic [3:0]        id_imm;
    logic [REG_W-1:0]  id_rd_addr;

    logic              fwd_em_en;
    logic [REG_W-1:0]  fwd_em_addr;
    logic [DATA_W-1:0] fwd_em_data;
    logic              fwd_mw_en;
    logic [REG_W-1:0]  fwd_mw_addr;
    logic [DATA_W-1:0] fwd_mw_data;

    logic              stall;
    logic              flush;

    logic              ex_valid;
    logic [REG_W-1:0]  ex_rd_addr;
    logic [DATA_W-1:0] ex_result;
    logic              ex_z;

    modport master (
        output id_valid, id_op, id_rs_addr, id_rs_data, id_imm, id_rd_addr,
        output fwd_em_en, fwd_em_addr, fwd_em_data,
        output fwd_mw_en, fwd_mw_addr, fwd_mw_data,
        output stall, flush,
        input  ex_valid, ex_rd_addr, ex_result, ex_z
    );

    modport slave (
        input  id_valid, id_op, id_rs_addr, id_rs_data, id_imm, id_rd_addr,
        input  fwd_em_en, fwd_em_addr, fwd_em_data,
        input  fwd_mw_en, fwd_mw_addr, fwd_mw_data,
        input  stall, flush,
        output ex_valid, ex_rd_addr, ex_result, ex_z
    );
endinterface
`default_nettype wire

// File: rtl/shift_ex_stage.sv
`default_nettype none
// ----------------------------------------------------------------------------
// shift_ex_stage : EX-stage SLL/SRA/ROR unit with operand forwarding and EX/MEM register
// Revision 1.0
// ----------------------------------------------------------------------------
module shift_ex_stage #(
    parameter int DATA_W = 16,
    parameter int REG_W  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    shift_ex_stage_if.slave   bus
);

    logic [DATA_W-1:0]   operand;
    logic [DATA_W-1:0]   shift_res;
    logic [2*DATA_W-1:0] rot_wide;

    logic              ex_valid_q,   ex_valid_d;
    logic [REG_W-1:0]  ex_rd_addr_q, ex_rd_addr_d;
    logic [DATA_W-1:0] ex_result_q,  ex_result_d;
    logic              ex_z_q,       ex_z_d;

    // Register 0 is hardwired zero, so it is never forwarded.
    always_comb begin
        operand = bus.id_rs_data;
        if (bus.id_rs_addr != '0) begin
            if (bus.fwd_em_en && (bus.fwd_em_addr == bus.id_rs_addr)) begin
                operand = bus.fwd_em_data;
            end else if (bus.fwd_mw_en && (bus.fwd_mw_addr == bus.id_rs_addr)) begin
                operand = bus.fwd_mw_data;
            end
        end
    end

    // Rotate by shifting a doubled copy right; the low half is the rotation.
    always_comb begin
        rot_wide  = {operand, operand} >> bus.id_imm;
        shift_res = operand;
        case (bus.id_op)
            2'b00:   shift_res = operand << bus.id_imm;
            2'b01:   shift_res = $signed(operand) >>> bus.id_imm;
            2'b10:   shift_res = rot_wide[DATA_W-1:0];
            default: shift_res = operand;
        endcase
    end

    always_comb begin
        ex_valid_d   = ex_valid_q;
        ex_rd_addr_d = ex_rd_addr_q;
        ex_result_d  = ex_result_q;
        ex_z_d       = ex_z_q;
        if (bus.flush) begin
            ex_valid_d = 1'b0;
        end else if (bus.stall) begin
            ex_valid_d = ex_valid_q;
        end else if (bus.id_valid) begin
            ex_valid_d   = 1'b1;
            ex_rd_addr_d = bus.id_rd_addr;
            ex_result_d  = shift_res;
            ex_z_d       = (shift_res == '0);
        end else begin
            ex_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ex_valid_q   <= 1'b0;
            ex_rd_addr_q <= '0;
            ex_result_q  <= '0;
            ex_z_q       <= 1'b0;
        end else begin
            ex_valid_q   <= ex_valid_d;
            ex_rd_addr_q <= ex_rd_addr_d;
            ex_result_q  <= ex_result_d;
            ex_z_q       <= ex_z_d;
        end
    end

    assign bus.ex_valid   = ex_valid_q;
    assign bus.ex_rd_addr = ex_rd_addr_q;
    assign bus.ex_result  = ex_result_q;
    assign bus.ex_z       = ex_z_q;

endmodule
`default_nettype wire

// File: tb/tb_shift_ex_stage.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_shift_ex_stage : directed vectors checked against an arithmetic reference model
// Revision 1.0
// ----------------------------------------------------------------------------
module tb_shift_ex_stage;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;
    logic chk_en;

    shift_ex_stage_if #(.DATA_W(16), .REG_W(4)) bus ();

    shift_ex_stage #(.DATA_W(16), .REG_W(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: shifts expressed as multiply / floor-divide / modular arithmetic.
    function automatic logic [15:0] model_shift(input logic [1:0] op, input logic [15:0] a,
                                                input int amt);
        int unsigned ua;
        int unsigned p;
        int          sa;
        ua = a;
        p  = 1 << amt;
        case (op)
            2'd0: return 16'((ua * p) % 65536);
            2'd1: begin
                sa = a[15] ? (int'(ua) - 65536) : int'(ua);
                if (sa < 0) sa = -((-sa + int'(p) - 1) / int'(p));
                else        sa = sa / int'(p);
                return 16'(sa);
            end
            2'd2: return 16'((ua / p) + ((ua % p) * (65536 / p)));
            default: return a;
        endcase
    endfunction

    function automatic logic [15:0] model_operand();
        if (bus.id_rs_addr == 4'd0) return bus.id_rs_data;
        if (bus.fwd_em_en && bus.fwd_em_addr == bus.id_rs_addr) return bus.fwd_em_data;
        if (bus.fwd_mw_en && bus.fwd_mw_addr == bus.id_rs_addr) return bus.fwd_mw_data;
        return bus.id_rs_data;
    endfunction

    logic        m_valid;
    logic [3:0]  m_rd;
    logic [15:0] m_res;
    logic        m_z;

    always @(posedge clk) begin
        logic [15:0] r;
        r = model_shift(bus.id_op, model_operand(), int'(bus.id_imm));
        if (!rst_n) begin
            m_valid <= 1'b0; m_rd <= 4'd0; m_res <= 16'd0; m_z <= 1'b0;
        end else if (bus.flush) begin
            m_valid <= 1'b0;
        end else if (!bus.stall) begin
            if (bus.id_valid) begin
                m_valid <= 1'b1; m_rd <= bus.id_rd_addr; m_res <= r; m_z <= (r == 16'd0);
            end else begin
                m_valid <= 1'b0;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("model.valid",  32'(bus.ex_valid),   32'(m_valid));
            check("model.rd",     32'(bus.ex_rd_addr), 32'(m_rd));
            check("model.result", 32'(bus.ex_result),  32'(m_res));
            check("model.z",      32'(bus.ex_z),       32'(m_z));
        end
    end

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [1:0] op, input logic [3:0] rs,
                         input logic [15:0] data, input logic [3:0] imm, input logic [3:0] rd);
        bus.id_valid   = v;
        bus.id_op      = op;
        bus.id_rs_addr = rs;
        bus.id_rs_data = data;
        bus.id_imm     = imm;
        bus.id_rd_addr = rd;
    endtask

    task automatic set_fwd(input logic em_en, input logic [3:0] em_a, input logic [15:0] em_d,
                           input logic mw_en, input logic [3:0] mw_a, input logic [15:0] mw_d);
        bus.fwd_em_en = em_en; bus.fwd_em_addr = em_a; bus.fwd_em_data = em_d;
        bus.fwd_mw_en = mw_en; bus.fwd_mw_addr = mw_a; bus.fwd_mw_data = mw_d;
    endtask

    task automatic expect_out(input string name, input logic v, input logic [3:0] rd,
                              input logic [15:0] res, input logic z);
        check($sformatf("%s.valid", name),  32'(bus.ex_valid),   32'(v));
        check($sformatf("%s.rd", name),     32'(bus.ex_rd_addr), 32'(rd));
        check($sformatf("%s.result", name), 32'(bus.ex_result),  32'(res));
        check($sformatf("%s.z", name),      32'(bus.ex_z),       32'(z));
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        chk_en   = 1'b0;
        rst_n    = 1'b0;
        bus.stall = 1'b0;
        bus.flush = 1'b0;
        drive(1'b0, 2'd0, 4'd0, 16'h0000, 4'd0, 4'd0);
        set_fwd(1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 16'h0);
        cycle();
        cycle();
        chk_en = 1'b1;
        expect_out("reset", 1'b0, 4'd0, 16'h0000, 1'b0);
        rst_n = 1'b1;

        drive(1'b1, 2'd1, 4'd1, 16'h8000, 4'd4, 4'd5);  cycle();
        expect_out("sra_8000_4", 1'b1, 4'd5, 16'hF800, 1'b0);
        drive(1'b1, 2'd1, 4'd1, 16'h7FFF, 4'd15, 4'd6); cycle();
        expect_out("sra_7fff_15", 1'b1, 4'd6, 16'h0000, 1'b1);
        drive(1'b1, 2'd0, 4'd2, 16'h0001, 4'd15, 4'd7); cycle();
        expect_out("sll_0001_15", 1'b1, 4'd7, 16'h8000, 1'b0);
        drive(1'b1, 2'd0, 4'd2, 16'h8000, 4'd1, 4'd8);  cycle();
        expect_out("sll_8000_1", 1'b1, 4'd8, 16'h0000, 1'b1);
        drive(1'b0, 2'd0, 4'd2, 16'h1111, 4'd1, 4'd9);  cycle();
        expect_out("bubble", 1'b0, 4'd8, 16'h0000, 1'b1);

        drive(1'b1, 2'd2, 4'd4, 16'h1234, 4'd4, 4'd1);  cycle();
        expect_out("ror_1234_4", 1'b1, 4'd1, 16'h4123, 1'b0);
        drive(1'b1, 2'd2, 4'd4, 16'h1234, 4'd0, 4'd2);  cycle();
        expect_out("ror_1234_0", 1'b1, 4'd2, 16'h1234, 1'b0);
        drive(1'b1, 2'd3, 4'd4, 16'hABCD, 4'd7, 4'd3);  cycle();
        expect_out("pass_abcd", 1'b1, 4'd3, 16'hABCD, 1'b0);

        set_fwd(1'b1, 4'd3, 16'h00F0, 1'b1, 4'd3, 16'hFFFF);
        drive(1'b1, 2'd1, 4'd3, 16'h0000, 4'd4, 4'd4);  cycle();
        expect_out("fwd_em", 1'b1, 4'd4, 16'h000F, 1'b0);
        set_fwd(1'b0, 4'd3, 16'h00F0, 1'b1, 4'd3, 16'hFFFF);
        cycle();
        expect_out("fwd_mw", 1'b1, 4'd4, 16'hFFFF, 1'b0);
        set_fwd(1'b1, 4'd0, 16'h00F0, 1'b1, 4'd0, 16'hFFFF);
        drive(1'b1, 2'd3, 4'd0, 16'h1230, 4'd0, 4'd5);  cycle();
        expect_out("fwd_r0", 1'b1, 4'd5, 16'h1230, 1'b0);
        set_fwd(1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 16'h0);

        drive(1'b1, 2'd3, 4'd6, 16'h00AA, 4'd0, 4'd6);  cycle();
        expect_out("load_00aa", 1'b1, 4'd6, 16'h00AA, 1'b0);
        bus.stall = 1'b1;
        drive(1'b1, 2'd0, 4'd6, 16'h0001, 4'd1, 4'd7);
        for (int i = 0; i < 3; i++) begin
            cycle();
            expect_out($sformatf("stall%0d", i), 1'b1, 4'd6, 16'h00AA, 1'b0);
        end
        bus.stall = 1'b0;
        cycle();
        expect_out("after_stall", 1'b1, 4'd7, 16'h0002, 1'b0);

        bus.stall = 1'b1;
        bus.flush = 1'b1;
        drive(1'b1, 2'd0, 4'd6, 16'h00FF, 4'd0, 4'd8);  cycle();
        expect_out("flush_stall", 1'b0, 4'd7, 16'h0002, 1'b0);
        bus.stall = 1'b0;
        bus.flush = 1'b0;

        drive(1'b1, 2'd2, 4'd6, 16'h00F0, 4'd4, 4'd9);  cycle();
        expect_out("pre_reset", 1'b1, 4'd9, 16'h000F, 1'b0);
        rst_n = 1'b0;
        cycle();
        expect_out("mid_reset", 1'b0, 4'd0, 16'h0000, 1'b0);
        rst_n = 1'b1;
        drive(1'b1, 2'd0, 4'd6, 16'h0003, 4'd2, 4'd10); cycle();
        expect_out("post_reset", 1'b1, 4'd10, 16'h000C, 1'b0);
        drive(1'b0, 2'd0, 4'd0, 16'h0000, 4'd0, 4'd0);  cycle();
        expect_out("final_bubble", 1'b0, 4'd10, 16'h000C, 1'b0);

        @(negedge clk);
        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/shift_ex_stage.md
# shift_ex_stage

Execute-stage shift unit for the 5-stage pipeline. It takes a decoded shift instruction from the ID/EX boundary and resolves its source operand through EX/MEM and MEM/WB forwarding. It then performs SLL, SRA or ROR by a 4-bit immediate and registers the result, destination and zero flag into the EX/MEM boundary, with stall and flush control from the hazard unit.

## Interface
- DATA_W, 16, datapath width; shift amount fixed at 4 bits
- REG_W, 4, register-address width; register 0 reads as zero
- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  reset, synchronous, active-low
- id_valid  in  1  ID/EX holds a valid shift instruction
- id_op  in  2  00 SLL, 01 SRA, 10 ROR, 11 pass-through (result = operand)
- id_rs_addr  in  REG_W  source register number
- id_rs_data  in  DATA_W  register-file read value for rs
- id_imm  in  4  shift amount 0..15
- id_rd_addr  in  REG_W  destination register number
- fwd_em_en / fwd_em_addr / fwd_em_data  in  1 / REG_W / DATA_W  EX/MEM writeback candidate
- fwd_mw_en / fwd_mw_addr / fwd_mw_data  in  1 / REG_W / DATA_W  MEM/WB writeback candidate
- stall  in  1  hold the EX/MEM output register
- flush  in  1  kill the instruction entering EX/MEM
- ex_valid  out  1  EX/MEM holds a valid result
- ex_rd_addr  out  REG_W  registered destination
- ex_result  out  DATA_W  registered shift result
- ex_z  out  1  persistent zero flag

## Operation
- Operand select is combinational and uses a fixed priority:
  - EX/MEM is used if fwd_em_en and fwd_em_addr == id_rs_addr and id_rs_addr != 0.
  - Otherwise MEM/WB is used under the same rule.
  - Otherwise id_rs_data is used.
  - If id_rs_addr == 0, the operand is id_rs_data regardless of forwarding.
- SLL shifts left and fills with zeros.
- SRA shifts right and fills with operand[15].
- ROR rotates right; bits leaving bit 0 re-enter at bit 15.
- An amount of 0 returns the operand unchanged for all ops.
- Result width is always DATA_W; no carry or overflow is produced.
- Register update, evaluated each rising edge in this priority:
  1. rst_n low: ex_valid=0, ex_rd_addr=0, ex_result=0x0000, ex_z=0.
  2. flush: ex_valid=0. ex_rd_addr, ex_result and ex_z hold. Flush overrides stall.
  3. stall: all outputs hold.
  4. id_valid: ex_valid=1, ex_rd_addr=id_rd_addr, ex_result=shift result, ex_z=(result==0).
  5. otherwise: ex_valid=0; data registers and ex_z hold.
- ex_z changes only on an accepted valid instruction, including op 11 (Z of the operand). It is never changed by a bubble, a flush or a stall.
- No internal state machine beyond the EX/MEM register. The block is a single-stage pipeline element.

## Timing
- Latency: 1 cycle. An instruction presented with id_valid on edge N appears on ex_* after edge N.
- Throughput: one instruction per cycle when stall is low.
- The forwarding inputs are sampled in the same cycle as the id_* inputs. The upstream hazard unit holds id_* stable during stall.
- A stall of K cycles holds ex_* for exactly K edges. The instruction on id_* is accepted on the first edge with stall low.
- Reset is honoured on any edge, including mid-stall or mid-flush. Outputs read their reset values after that edge.
- All outputs are registered; no combinational path runs from inputs to outputs.

## Test plan
- SRA of rs data 0x8000 by 4 with id_valid -> next cycle ex_valid=1, ex_result=0xF800, ex_z=0. SRA of 0x7FFF by 15 -> 0x0000, ex_z=1.
- SLL 0x0001 by 15 -> 0x8000. Then SLL 0x8000 by 1 -> 0x0000, ex_z=1. Then a bubble -> ex_valid=0, ex_z stays 1.
- ROR 0x1234 by 4 -> 0x4123; ROR 0x1234 by 0 -> 0x1234; op 11 on 0xABCD -> 0xABCD.
- Forwarding with rs=3, id_rs_data=0x0000, EX/MEM (3, 0x00F0) and MEM/WB (3, 0xFFFF), SRA by 4 -> 0x000F.
  - With EX/MEM disabled -> 0xFFFF.
  - With rs=0 and both forwards matching address 0 -> result is from id_rs_data.
- Stall: load 0x00AA, then assert stall for 3 cycles while presenting SLL 0x0001 by 1 -> ex_* unchanged for 3 cycles, then 0x0002. Flush+stall together -> ex_valid=0, ex_result and ex_z unchanged.
- Reset: drive rst_n low for one edge during a stream of valid ops -> ex_valid=0, ex_rd_addr=0, ex_result=0x0000, ex_z=0. The first valid op after release produces a correct result one cycle later.
